// File: rtl/obj_rain_pkg.sv
// Shared types, constants and geometry helper for the falling-object engine.
package obj_rain_pkg;

  localparam int COORD_W = 12;
  localparam int IDX_W   = 3;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  // Half-open interval test [a0, a0+len_a) vs [b0, b0+len_b), widened so sums never wrap.
  function automatic logic overlap(
    input logic [COORD_W:0] a0,
    input logic [COORD_W:0] len_a,
    input logic [COORD_W:0] b0,
    input logic [COORD_W:0] len_b
  );
    logic [COORD_W+1:0] a_end;
    logic [COORD_W+1:0] b_end;
    a_end = {1'b0, a0} + {1'b0, len_a};
    b_end = {1'b0, b0} + {1'b0, len_b};
    return ({1'b0, a0} < b_end) && ({1'b0, b0} < a_end);
  endfunction

endpackage

// File: rtl/obj_rain_engine_lfsr.sv
// 16-bit Fibonacci LFSR used to pick spawn columns; advances only on step.
module obj_lfsr16
  import obj_rain_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic feedback;

  assign feedback = ^(value & LFSR_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= seed;
    end else if (step) begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/obj_rain_engine.sv
// Multi-slot falling-object engine: per-frame spawn/fall/catch/miss sweep,
// score keeping and a registered per-pixel object lookup for the colour mux.
module obj_rain_engine
  import obj_rain_pkg::*;
#(
  parameter int          N_OBJ     = 4,
  parameter int          OBJ_W     = 40,
  parameter int          OBJ_H     = 40,
  parameter int          SCR_W     = 640,
  parameter int          SCR_H     = 480,
  parameter int          STEP      = 2,
  parameter int          PLAYER_W  = 80,
  parameter int          PLAYER_H  = 20,
  parameter int          MAX_MISS  = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               pix_on,
  output logic [2:0]         pix_id,
  output logic [N_OBJ-1:0]   obj_active,
  output logic               catch_pulse,
  output logic [7:0]         score,
  output logic [3:0]         miss_cnt,
  output logic               end_show,
  output logic               busy
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W:0]   OBJ_W_C    = CW1'(OBJ_W);
  localparam logic [COORD_W:0]   OBJ_H_C    = CW1'(OBJ_H);
  localparam logic [COORD_W:0]   PLAYER_W_C = CW1'(PLAYER_W);
  localparam logic [COORD_W:0]   PLAYER_H_C = CW1'(PLAYER_H);
  localparam logic [COORD_W:0]   STEP_C     = CW1'(STEP);
  localparam logic [COORD_W:0]   ONE_C      = CW1'(1);
  localparam logic [COORD_W:0]   MISS_Y_C   = CW1'(SCR_H - OBJ_H);
  localparam logic [COORD_W-1:0] SPAWN_SPAN = COORD_W'(SCR_W - OBJ_W);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_OBJ - 1);
  localparam logic [3:0]         MISS_MAX_C = 4'(MAX_MISS);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic               spawned_q;
  logic               spawned_d;

  logic [COORD_W-1:0] x_q [N_OBJ];
  logic [COORD_W-1:0] y_q [N_OBJ];
  logic [N_OBJ-1:0]   act_q;

  logic [15:0]        lfsr_val;
  logic               lfsr_unused;
  logic [COORD_W-1:0] spawn_x;

  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               cur_act;
  logic [COORD_W:0]   ny;
  logic               in_sweep;
  logic               do_spawn;
  logic               do_catch;
  logic               do_miss;
  logic               do_move;

  logic [N_OBJ-1:0]   hit_p0;
  logic               pix_on_p0;
  logic [2:0]         pix_id_p0;

  obj_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (do_spawn),
    .seed  (LFSR_SEED),
    .value (lfsr_val)
  );

  assign lfsr_unused = ^lfsr_val[15:10];
  assign obj_active  = act_q;

  // Fold the 10-bit random value back into the legal left-edge range.
  always_comb begin
    spawn_x = {2'b00, lfsr_val[9:0]};
    if (spawn_x >= SPAWN_SPAN) begin
      spawn_x = spawn_x - SPAWN_SPAN;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    spawned_d = spawned_q;
    unique case (state_q)
      IDLE: begin
        if (frame_tick && enable && !end_show) begin
          state_d   = SWEEP;
          idx_d     = '0;
          spawned_d = 1'b0;
        end
      end
      SWEEP: begin
        if (do_spawn) begin
          spawned_d = 1'b1;
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Evaluate the slot under the sweep pointer; catch outranks miss.
  always_comb begin
    cur_x   = '0;
    cur_y   = '0;
    cur_act = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_x   = x_q[i];
        cur_y   = y_q[i];
        cur_act = act_q[i];
      end
    end
    in_sweep = (state_q == SWEEP);
    ny       = {1'b0, cur_y} + STEP_C;
    do_spawn = in_sweep && !cur_act && !spawned_q;
    do_catch = in_sweep && cur_act &&
               overlap({1'b0, cur_x}, OBJ_W_C, {1'b0, player_x}, PLAYER_W_C) &&
               overlap(ny, OBJ_H_C, {1'b0, player_y}, PLAYER_H_C);
    do_miss  = in_sweep && cur_act && !do_catch && (ny >= MISS_Y_C);
    do_move  = in_sweep && cur_act && !do_catch && !do_miss;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      spawned_q <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      spawned_q <= spawned_d;
      busy      <= (state_d == SWEEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_OBJ; i++) begin
        if (idx_q == IDX_W'(i)) begin
          if (do_spawn) begin
            x_q[i]   <= spawn_x;
            y_q[i]   <= '0;
            act_q[i] <= 1'b1;
          end
          if (do_catch || do_miss) begin
            act_q[i] <= 1'b0;
          end
          if (do_move) begin
            y_q[i] <= ny[COORD_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      catch_pulse <= 1'b0;
      score       <= '0;
      miss_cnt    <= '0;
      end_show    <= 1'b0;
    end else begin
      catch_pulse <= do_catch;
      if (do_catch && (score != 8'hFF)) begin
        score <= score + 8'd1;
      end
      if (do_miss && (miss_cnt < MISS_MAX_C)) begin
        miss_cnt <= miss_cnt + 4'd1;
        if (miss_cnt == MISS_MAX_C - 4'd1) begin
          end_show <= 1'b1;
        end
      end
    end
  end

  // Pixel lookup: p0 is the combinational hit, registered into pix_on/pix_id.
  always_comb begin
    pix_id_p0 = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      hit_p0[i] = act_q[i] &&
                  overlap({1'b0, px}, ONE_C, {1'b0, x_q[i]}, OBJ_W_C) &&
                  overlap({1'b0, py}, ONE_C, {1'b0, y_q[i]}, OBJ_H_C);
    end
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit_p0[i]) begin
        pix_id_p0 = 3'(i);
      end
    end
    pix_on_p0 = |hit_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_on <= 1'b0;
      pix_id <= '0;
    end else begin
      pix_on <= pix_on_p0;
      pix_id <= pix_id_p0;
    end
  end

endmodule

// File: tb/tb_obj_rain_engine.sv
// Self-checking bench for obj_rain_engine against a frame-level behavioural model.
module tb_obj_rain_engine;

  localparam int N_OBJ    = 4;
  localparam int OBJ_W    = 40;
  localparam int OBJ_H    = 40;
  localparam int SCR_W    = 640;
  localparam int SCR_H    = 480;
  localparam int STEP     = 2;
  localparam int PLAYER_W = 80;
  localparam int PLAYER_H = 20;
  localparam int MAX_MISS = 5;

  logic             clk;
  logic             rst;
  logic             frame_tick;
  logic             enable;
  logic [11:0]      player_x;
  logic [11:0]      player_y;
  logic [11:0]      px;
  logic [11:0]      py;
  logic             pix_on;
  logic [2:0]       pix_id;
  logic [N_OBJ-1:0] obj_active;
  logic             catch_pulse;
  logic [7:0]       score;
  logic [3:0]       miss_cnt;
  logic             end_show;
  logic             busy;

  obj_rain_engine #(
    .N_OBJ(N_OBJ), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .SCR_W(SCR_W), .SCR_H(SCR_H),
    .STEP(STEP), .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H), .MAX_MISS(MAX_MISS),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .player_x(player_x), .player_y(player_y), .px(px), .py(py),
    .pix_on(pix_on), .pix_id(pix_id), .obj_active(obj_active),
    .catch_pulse(catch_pulse), .score(score), .miss_cnt(miss_cnt),
    .end_show(end_show), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int mx [N_OBJ];
  int my [N_OBJ];
  bit mact [N_OBJ];
  int mlfsr;
  int mscore;
  int mmiss;
  bit mend;
  int last_maxrun;

  typedef struct {
    int qx;
    int qy;
    int on;
    int id;
  } pix_vec_t;
  pix_vec_t pv [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) & 16'hFFFF) | fb;
  endfunction

  function automatic bit ovl(input int a0, input int la, input int b0, input int lb);
    return (a0 < b0 + lb) && (b0 < a0 + la);
  endfunction

  function automatic int m_active();
    int v;
    v = 0;
    for (int i = 0; i < N_OBJ; i++) if (mact[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_OBJ; i++) begin
      mx[i] = 0; my[i] = 0; mact[i] = 0;
    end
    mlfsr = 16'hACE1; mscore = 0; mmiss = 0; mend = 0;
  endtask

  task automatic model_frame(input bit en_v, output int catches);
    bit sp;
    int nyv;
    int xr;
    catches = 0;
    sp = 0;
    if (!en_v || mend) return;
    for (int i = 0; i < N_OBJ; i++) begin
      if (!mact[i]) begin
        if (!sp) begin
          xr = mlfsr % 1024;
          if (xr >= SCR_W - OBJ_W) xr -= SCR_W - OBJ_W;
          mx[i] = xr; my[i] = 0; mact[i] = 1; sp = 1;
          mlfsr = lfsr_next(mlfsr);
        end
      end else begin
        nyv = my[i] + STEP;
        if (ovl(mx[i], OBJ_W, int'(player_x), PLAYER_W) && ovl(nyv, OBJ_H, int'(player_y), PLAYER_H)) begin
          mact[i] = 0; catches++;
          if (mscore < 255) mscore++;
        end else if (nyv >= SCR_H - OBJ_H) begin
          mact[i] = 0;
          if (mmiss < MAX_MISS) begin
            mmiss++;
            if (mmiss == MAX_MISS) mend = 1;
          end
        end else begin
          my[i] = nyv;
        end
      end
    end
  endtask

  function automatic void model_pix(input int qx, input int qy, output int on, output int id);
    on = 0; id = 0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (mact[i] && qx >= mx[i] && qx < mx[i] + OBJ_W && qy >= my[i] && qy < my[i] + OBJ_H) begin
        on = 1; id = i;
      end
    end
  endfunction

  task automatic pix_check(input int qx, input int qy);
    int on;
    int id;
    px = 12'(qx); py = 12'(qy);
    tick();
    model_pix(qx, qy, on, id);
    check("pix_on", int'(pix_on), on);
    check("pix_id", int'(pix_id), id);
  endtask

  task automatic pix_objs();
    for (int i = 0; i < N_OBJ; i++) begin
      if (mact[i]) begin
        pix_check(mx[i], my[i]);
        pix_check(mx[i] + OBJ_W / 2, my[i] + OBJ_H / 2);
        pix_check(mx[i] + OBJ_W, my[i]);
        pix_check(mx[i] + OBJ_W - 1, my[i] + OBJ_H);
      end
    end
  endtask

  task automatic run_frame(input bit en_v, input bit extra);
    int busy_n;
    int pulse_n;
    int run;
    int maxrun;
    int exp_busy;
    int exp_c;
    busy_n = 0; pulse_n = 0; run = 0; maxrun = 0;
    exp_busy = (en_v && !mend) ? N_OBJ : 0;
    model_frame(en_v, exp_c);
    enable = en_v;
    frame_tick = 1'b1;
    tick();
    for (int c = 0; c < N_OBJ + 4; c++) begin
      if (busy) busy_n++;
      if (catch_pulse) begin
        pulse_n++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      frame_tick = (extra && c == 1);
      tick();
    end
    frame_tick = 1'b0;
    last_maxrun = maxrun;
    check("busy_cycles", busy_n, exp_busy);
    check("catch_pulses", pulse_n, exp_c);
    check("obj_active", int'(obj_active), m_active());
    check("score", int'(score), mscore);
    check("miss_cnt", int'(miss_cnt), mmiss);
    check("end_show", int'(end_show), int'(mend));
  endtask

  task automatic check_reset_vals();
    check("rst_obj_active", int'(obj_active), 0);
    check("rst_score", int'(score), 0);
    check("rst_miss_cnt", int'(miss_cnt), 0);
    check("rst_end_show", int'(end_show), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_catch_pulse", int'(catch_pulse), 0);
    check("rst_pix_on", int'(pix_on), 0);
    check("rst_pix_id", int'(pix_id), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_vals();
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pv[0] = '{225, 10, 1, 0};
    pv[1] = '{225, 0, 1, 0};
    pv[2] = '{264, 39, 1, 0};
    pv[3] = '{265, 10, 0, 0};
    pv[4] = '{224, 10, 0, 0};
    pv[5] = '{225, 40, 0, 0};

    rst = 1'b1; frame_tick = 1'b0; enable = 1'b1;
    player_x = 12'd600; player_y = 12'd460; px = 12'd0; py = 12'd0;
    model_reset();
    tick(); tick();
    check_reset_vals();
    rst = 1'b0;
    tick();

    // First spawn lands at x=225, y=0, only slot 0 active
    run_frame(1'b1, 1'b0);
    check("first_spawn_active", int'(obj_active), 1);
    for (int k = 0; k < 6; k++) begin
      px = 12'(pv[k].qx); py = 12'(pv[k].qy);
      tick();
      check("pix_table_on", int'(pix_on), pv[k].on);
      check("pix_table_id", int'(pix_id), pv[k].id);
    end

    // Slot 0 falls to the bottom and is counted as a miss
    for (int f = 0; f < 220; f++) begin
      run_frame(1'b1, 1'b0);
      if (f % 8 == 0) pix_objs();
    end
    check("slot0_missed", int'(obj_active[0]), 0);
    pix_objs();

    // Catch: player under the first object, caught at ny=62 (frame 32)
    do_reset();
    player_x = 12'd225; player_y = 12'd100;
    for (int f = 1; f <= 31; f++) run_frame(1'b1, 1'b0);
    check("pre_catch_active0", int'(obj_active[0]), 1);
    pix_objs();
    run_frame(1'b1, 1'b0);
    check("catch_score", int'(score), 1);
    check("catch_pulse_width", last_maxrun, 1);
    check("catch_slot_freed", int'(obj_active[0]), 0);
    run_frame(1'b1, 1'b0);
    check("catch_respawn", int'(obj_active[0]), 1);
    pix_objs();

    // Five misses with the player off-screen end the game
    do_reset();
    player_x = 12'd2000; player_y = 12'd2000;
    for (int f = 0; f < 2000 && !mend; f++) begin
      run_frame(1'b1, 1'b0);
      if (f % 16 == 0) pix_objs();
    end
    check("end_show_set", int'(end_show), 1);
    check("end_miss_cnt", int'(miss_cnt), MAX_MISS);
    pix_objs();
    for (int f = 0; f < 3; f++) run_frame(1'b1, 1'b0);
    pix_objs();
    do_reset();
    tick();
    check_reset_vals();

    // Reset in the middle of a sweep aborts it asynchronously
    player_x = 12'd600; player_y = 12'd460;
    enable = 1'b1; frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    check("midsweep_busy", int'(busy), 1);
    do_reset();
    pix_check(225, 0);
    run_frame(1'b1, 1'b0);
    pix_check(225, 0);
    check("respawn_x225_on", int'(pix_on), 1);

    // Extra frame_tick inside a sweep is dropped; enable low freezes everything
    run_frame(1'b1, 1'b1);
    pix_objs();
    run_frame(1'b0, 1'b0);
    pix_objs();
    enable = 1'b1;

    // Randomized play against the model
    do_reset();
    for (int f = 0; f < 300; f++) begin
      player_x = 12'($urandom_range(0, 600));
      player_y = 12'($urandom_range(200, 470));
      run_frame($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0);
      pix_objs();
      pix_check($urandom_range(0, SCR_W - 1), $urandom_range(0, SCR_H - 1));
      pix_check($urandom_range(0, SCR_W - 1), $urandom_range(0, SCR_H - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obj_rain_engine.md
Name: obj_rain_engine

Overview:
- Parametrised successor to the single falling-sprite mover.
- Manages N_OBJ independent falling objects in 640x480 active-area coordinates.
- Per frame it spawns objects at pseudo-random x, advances them by STEP, and detects catches against a player box and misses at the bottom edge.
- Keeps score and miss count, raises a sticky end_show, and answers a registered per-pixel "object here" query for the VGA colour mux.

Parameters:
- N_OBJ, 4, number of object slots (1..8).
- OBJ_W, 40, object width in pixels.
- OBJ_H, 40, object height in pixels.
- SCR_W, 640, active width.
- SCR_H, 480, active height.
- STEP, 2, pixels fallen per frame.
- PLAYER_W, 80, player box width.
- PLAYER_H, 20, player box height.
- MAX_MISS, 5, misses that end the game.
- LFSR_SEED, 16'hACE1, reset value of the x generator (must be non-zero).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- enable  in  1  frame updates allowed when high.
- player_x  in  12  player box left edge.
- player_y  in  12  player box top edge.
- px  in  12  pixel query x (active-area).
- py  in  12  pixel query y (active-area).
- pix_on  out  1  queried pixel lies inside an active object (registered).
- pix_id  out  3  lowest-index object covering the queried pixel (registered).
- obj_active  out  N_OBJ  per-slot active flags.
- catch_pulse  out  1  one-cycle pulse per catch.
- score  out  8  catches, saturating at 255.
- miss_cnt  out  4  misses, saturating at MAX_MISS.
- end_show  out  1  game over, sticky.
- busy  out  1  update sweep in progress.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: all slots inactive, all obj x and y = 0, lfsr = LFSR_SEED, score = 0, miss_cnt = 0, end_show = 0, catch_pulse = 0, pix_on = 0, pix_id = 0, busy = 0, FSM = IDLE.
- Reset mid-sweep aborts the sweep and restores all reset values.
- FSM states are IDLE, SWEEP and DONE.
- IDLE -> SWEEP on frame_tick && enable && !end_show. On entry idx = 0, spawned = 0, busy = 1.
- SWEEP processes slot idx in one cycle and then increments idx. After idx = N_OBJ-1 it goes to DONE. A sweep lasts exactly N_OBJ cycles.
- DONE -> IDLE on the next cycle, with busy = 0.
- frame_tick arriving while the FSM is not in IDLE is dropped; there is no queuing.
- Inactive slot with spawned == 0:
  - x = lfsr[9:0], or lfsr[9:0] - (SCR_W-OBJ_W) when lfsr[9:0] >= SCR_W-OBJ_W.
  - y = 0, active = 1, spawned = 1.
  - lfsr advances one step (Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0).
  - At most one spawn per frame. Other inactive slots stay inactive.
- Active slot: ny = y + STEP. The checks are priority-ordered:
  - Catch when [x, x+OBJ_W) overlaps [player_x, player_x+PLAYER_W) and [ny, ny+OBJ_H) overlaps [player_y, player_y+PLAYER_H). The slot is deactivated, score increments (saturating at 255), and catch_pulse is asserted the next cycle.
  - Else miss when ny >= SCR_H-OBJ_H. The slot is deactivated and miss_cnt increments. When the new miss_cnt equals MAX_MISS, end_show = 1 from the next cycle.
  - Else y = ny.
- Catch takes priority over miss when both hold in the same evaluation.
- When end_show rises mid-sweep, the sweep completes. Later frame_ticks are ignored and objects freeze while still being displayed. Only rst clears end_show.
- When enable is low, objects freeze. The pixel query keeps working.
- Pixel query has 1-cycle latency.
  - pix_on(t+1) = OR over active slots of (x <= px < x+OBJ_W && y <= py < y+OBJ_H), evaluated on inputs at t.
  - pix_id is the lowest matching index, or 0 when there is no match.
- Arithmetic: all coordinate arithmetic is 12-bit unsigned. Sums are evaluated at 13 bits so no wrap occurs.

Decomposition:
- Package obj_rain_pkg holds:
  - COORD_W = 12.
  - the FSM state enum (IDLE, SWEEP, DONE).
  - LFSR tap constant.
  - overlap function (a0, len_a, b0, len_b).
- Sub-module obj_lfsr16 is natural: it takes clk, rst, step and seed, and outputs the 16-bit value.

Test Plan:
- Reset, then one frame_tick with the player far away (player_x = 600, player_y = 460) -> slot 0 spawns at x = 225 (0x0E1), y = 0; busy high for 4 cycles; other slots stay inactive.
- 220 further frame_ticks with the player far away -> slot 0 reaches ny = 440 and is deactivated; miss_cnt = 1; slots 1..3 have spawned on successive frames.
- Player at (225, 100), single object falling from y = 0 -> catch when ny = 62 (62+40 > 100); catch_pulse is one cycle wide; score = 1; the slot frees and respawns next frame.
- Five misses forced with the player parked off-screen -> end_show = 1 after the fifth miss; further frame_ticks leave all y values unchanged; rst clears everything.
- frame_tick pulsed on the 2nd cycle of a sweep and with enable = 0 -> no extra sweep occurs and positions are unchanged.
- Pixel query: object at (225, 10), px = 225, py = 10 -> pix_on = 1 and pix_id = 0 one cycle later; px = 265 -> pix_on = 0. Overlapping slots 1 and 2 -> pix_id = 1.
